// File: rtl/enemy_patrol.sv
// Patrolling enemy: walks between X_MIN and X_MAX, reverses on bump,
// and shows a squashed sprite for a while when stomped before disappearing.
module enemy_patrol #(
  parameter int XW            = 5,
  parameter int TICK_CYCLES   = 37800000,
  parameter int SQUASH_CYCLES = 12600000,
  parameter int X_MIN         = 24,
  parameter int X_MAX         = 26,
  parameter int X_INIT        = 24,
  parameter int Y_INIT        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    game_state,
  input  logic          stomp,
  input  logic          bump,
  input  logic          fast,
  output logic [XW-1:0] enemy_x,
  output logic [XW-1:0] enemy_y,
  output logic          enemy_dir,
  output logic          enemy_alive,
  output logic          squash,
  output logic          step
);

  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam int SW = $clog2(SQUASH_CYCLES + 1);

  localparam logic [CW-1:0] P_NORM = CW'(TICK_CYCLES);
  localparam logic [CW-1:0] P_FAST = CW'(TICK_CYCLES / 2);
  localparam logic [CW-1:0] CNT_1  = CW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(SQUASH_CYCLES - 1);
  localparam logic [XW-1:0] XMIN   = XW'(X_MIN);
  localparam logic [XW-1:0] XMAX   = XW'(X_MAX);
  localparam logic [XW-1:0] XINIT  = XW'(X_INIT);
  localparam logic [XW-1:0] X_ONE  = XW'(1);

  localparam logic [1:0] GS_END   = 2'd0;
  localparam logic [1:0] GS_ING   = 2'd1;
  localparam logic [1:0] GS_START = 2'd2;
  localparam logic [1:0] GS_PAUSE = 2'd3;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_MOVING,
    ST_SQUASHED,
    ST_DEAD
  } state_e;

  state_e        state_q;
  logic [XW-1:0] x_q;
  logic          dir_q;
  logic          alive_q;
  logic          squash_q;
  logic          step_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] scnt_q;

  logic [CW-1:0] per;
  logic          tick;
  logic          dir_b;
  logic          dir_d;
  logic [XW-1:0] x_d;

  // bump flips direction before the bound check so a coincident tick
  // steps the new way
  always_comb begin
    per   = fast ? P_FAST : P_NORM;
    tick  = (cnt_q >= per);
    dir_b = dir_q ^ bump;
    dir_d = dir_b;
    x_d   = x_q;
    if (dir_b) begin
      if (x_q >= XMAX) begin
        dir_d = 1'b0;
        x_d   = x_q - X_ONE;
      end else begin
        x_d   = x_q + X_ONE;
      end
    end else begin
      if (x_q <= XMIN) begin
        dir_d = 1'b1;
        x_d   = x_q + X_ONE;
      end else begin
        x_d   = x_q - X_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_STOP;
      x_q      <= XINIT;
      dir_q    <= 1'b1;
      alive_q  <= 1'b1;
      squash_q <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= CNT_1;
      scnt_q   <= '0;
    end else if (game_state == GS_START) begin
      state_q  <= ST_STOP;
      x_q      <= XINIT;
      dir_q    <= 1'b1;
      alive_q  <= 1'b1;
      squash_q <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= CNT_1;
      scnt_q   <= '0;
    end else if (game_state == GS_PAUSE) begin
      step_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        ST_STOP: begin
          cnt_q <= CNT_1;
          if (game_state == GS_ING) begin
            state_q <= ST_MOVING;
          end
        end
        ST_MOVING: begin
          if (stomp) begin
            state_q  <= ST_SQUASHED;
            squash_q <= 1'b1;
            cnt_q    <= CNT_1;
            scnt_q   <= '0;
          end else if (game_state == GS_ING) begin
            if (tick) begin
              cnt_q  <= CNT_1;
              x_q    <= x_d;
              dir_q  <= dir_d;
              step_q <= 1'b1;
            end else begin
              cnt_q  <= cnt_q + CNT_1;
              dir_q  <= dir_b;
            end
          end else begin
            state_q <= ST_STOP;
            cnt_q   <= CNT_1;
          end
        end
        ST_SQUASHED: begin
          if (game_state == GS_END || scnt_q >= S_LAST) begin
            state_q  <= ST_DEAD;
            squash_q <= 1'b0;
            alive_q  <= 1'b0;
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
        end
        ST_DEAD: begin
          cnt_q <= CNT_1;
        end
        default: begin
          state_q <= ST_STOP;
        end
      endcase
    end
  end

  assign enemy_x     = x_q;
  assign enemy_y     = XW'(Y_INIT);
  assign enemy_dir   = dir_q;
  assign enemy_alive = alive_q;
  assign squash      = squash_q;
  assign step        = step_q;

endmodule

// File: tb/tb_enemy_patrol.sv
// Directed bench for enemy_patrol with TICK_CYCLES=4, SQUASH_CYCLES=3.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_enemy_patrol;

  logic       clk;
  logic       reset;
  logic [1:0] game_state;
  logic       stomp;
  logic       bump;
  logic       fast;
  logic [4:0] enemy_x;
  logic [4:0] enemy_y;
  logic       enemy_dir;
  logic       enemy_alive;
  logic       squash;
  logic       step;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] END   = 2'd0;
  localparam logic [1:0] ING   = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  enemy_patrol #(
    .XW(5),
    .TICK_CYCLES(4),
    .SQUASH_CYCLES(3),
    .X_MIN(24),
    .X_MAX(26),
    .X_INIT(24),
    .Y_INIT(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .game_state(game_state),
    .stomp(stomp),
    .bump(bump),
    .fast(fast),
    .enemy_x(enemy_x),
    .enemy_y(enemy_y),
    .enemy_dir(enemy_dir),
    .enemy_alive(enemy_alive),
    .squash(squash),
    .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int d);
    chk({tag, ".x"}, 32'(enemy_x), 32'(x));
    chk({tag, ".dir"}, 32'(enemy_dir), 32'(d));
  endtask

  int xs[5] = '{25, 26, 25, 24, 25};
  int ds[5] = '{1, 1, 0, 0, 1};

  initial begin
    reset = 1'b0;
    game_state = ING;
    stomp = 1'b0;
    bump = 1'b0;
    fast = 1'b0;
    cyc(2);
    chk_pos("rst", 24, 1);
    chk("rst.y", 32'(enemy_y), 12);
    chk("rst.alive", 32'(enemy_alive), 1);
    chk("rst.squash", 32'(squash), 0);
    chk("rst.step", 32'(step), 0);

    // normal patrol: enter MOVING, then a step every 4 cycles
    reset = 1'b1;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      cyc(3);
      chk("patrol.hold", 32'(step), 0);
      chk("patrol.still", 32'(enemy_x), 32'(k == 0 ? 24 : xs[k-1]));
      cyc(1);
      chk_pos("patrol", xs[k], ds[k]);
      chk("patrol.step", 32'(step), 1);
    end

    // fast: step every 2 cycles
    fast = 1'b1;
    cyc(1);
    chk("fast.wait", 32'(enemy_x), 25);
    cyc(1);
    chk_pos("fast1", 26, 1);
    cyc(2);
    chk_pos("fast2", 25, 0);
    fast = 1'b0;
    cyc(2);
    chk("slow.cnt3", 32'(enemy_x), 25);
    fast = 1'b1;
    cyc(1);
    chk_pos("fast.late", 24, 0);
    chk("fast.late.step", 32'(step), 1);
    fast = 1'b0;

    // bump alone, then bump with tick
    cyc(4);
    chk_pos("pre.bump", 25, 1);
    bump = 1'b1;
    cyc(1);
    chk_pos("bump.alone", 25, 0);
    chk("bump.nostep", 32'(step), 0);
    cyc(1);
    chk_pos("bump.back", 25, 1);
    bump = 1'b0;
    cyc(1);
    bump = 1'b1;
    cyc(1);
    chk_pos("bump.tick", 24, 0);
    bump = 1'b0;

    // pause mid-period keeps the count; stomp/bump ignored
    cyc(2);
    game_state = PAUSE;
    stomp = 1'b1;
    bump = 1'b1;
    cyc(10);
    chk_pos("pause", 24, 0);
    chk("pause.squash", 32'(squash), 0);
    stomp = 1'b0;
    bump = 1'b0;
    game_state = ING;
    cyc(1);
    chk("resume.wait", 32'(enemy_x), 24);
    cyc(1);
    chk_pos("resume", 25, 1);

    // END during MOVING drops to STOP with counter reset
    cyc(2);
    game_state = END;
    cyc(2);
    chk_pos("end", 25, 1);
    game_state = ING;
    cyc(4);
    chk("end.restart", 32'(enemy_x), 25);
    cyc(1);
    chk_pos("end.step", 26, 1);

    // stomp, squash for 3 cycles, then dead
    cyc(4);
    chk_pos("pre.stomp", 25, 0);
    stomp = 1'b1;
    cyc(1);
    stomp = 1'b0;
    chk("sq.c1", 32'(squash), 1);
    chk("sq.alive", 32'(enemy_alive), 1);
    cyc(2);
    chk("sq.c3", 32'(squash), 1);
    chk("sq.x", 32'(enemy_x), 25);
    cyc(1);
    chk("dead.squash", 32'(squash), 0);
    chk("dead.alive", 32'(enemy_alive), 0);
    stomp = 1'b1;
    bump = 1'b1;
    cyc(2);
    stomp = 1'b0;
    bump = 1'b0;
    chk_pos("dead.frozen", 25, 0);
    chk("dead.stay", 32'(enemy_alive), 0);

    // START reinitialises into STOP
    game_state = START;
    cyc(1);
    chk_pos("start", 24, 1);
    chk("start.alive", 32'(enemy_alive), 1);
    chk("start.y", 32'(enemy_y), 12);
    game_state = ING;
    cyc(4);
    chk("start.stop", 32'(enemy_x), 24);
    cyc(1);
    chk("start.step", 32'(enemy_x), 25);

    // END during SQUASHED kills immediately
    stomp = 1'b1;
    cyc(1);
    stomp = 1'b0;
    chk("sqend.sq", 32'(squash), 1);
    game_state = END;
    cyc(1);
    chk("sqend.alive", 32'(enemy_alive), 0);
    game_state = START;
    cyc(1);
    game_state = ING;
    cyc(5);
    chk_pos("again", 25, 1);

    // async reset during SQUASHED
    stomp = 1'b1;
    cyc(1);
    stomp = 1'b0;
    cyc(1);
    chk("arst.pre", 32'(squash), 1);
    reset = 1'b0;
    #2;
    chk_pos("arst", 24, 1);
    chk("arst.squash", 32'(squash), 0);
    chk("arst.alive", 32'(enemy_alive), 1);
    cyc(1);
    reset = 1'b1;
    cyc(4);
    chk("arst.full", 32'(enemy_x), 24);
    cyc(1);
    chk("arst.step", 32'(enemy_x), 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
